// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tone_sequencer
// Queues {period, duration} note commands and plays them back to back on a
// pulse oscillator. Optional macro TONE_SEQ_GAP_EN adds a silent gap per note.
// Rev    : 1.0  initial release
// ============================================================================
module tone_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TICK_DIV   = 48000,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_period,
  input  logic [15:0] cmd_duration,
  input  logic        flush,
  output logic [31:0] count_max,
  output logic        osc_enable,
  output logic        busy,
  output logic        note_done
);

  localparam int unsigned c_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
`ifdef TONE_SEQ_GAP_EN
    S_GAP  = 2'd2,
`endif
    S_IDLE = 2'd0,
    S_PLAY = 2'd1
  } state_t;

  logic [47:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W:0]    r_wr_ptr;
  logic [c_ADDR_W:0]    r_rd_ptr;
  state_t               r_state;
  logic [c_PRESC_W-1:0] r_presc;
  logic [15:0]          r_rem;
  logic [31:0]          r_count_max;
  logic                 r_osc_en;
  logic                 r_busy;
  logic                 r_note_done;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_tick;
  logic                 w_head_ok;
  logic [31:0]          w_head_period;
  logic [15:0]          w_head_dur;
  logic [c_ADDR_W:0]    w_wr_nxt;
  logic [c_ADDR_W:0]    w_rd_nxt;
  state_t               w_state_nxt;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_done;
  logic                 w_silence;
  logic [c_PRESC_W-1:0] w_presc_nxt;
  logic [15:0]          w_rem_nxt;

`ifdef TONE_SEQ_GAP_EN
  localparam int unsigned c_GAP_W = $clog2(GAP_TICKS + 1);
  logic [c_GAP_W-1:0] r_gap;
  logic [c_GAP_W-1:0] w_gap_nxt;
`else
  // GAP_TICKS only matters when the gap feature is compiled in.
  if (GAP_TICKS == 0) begin : g_gap_unused
  end
`endif

  // Pointers carry a wrap bit: equal means empty, differing only in the MSB means full.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {c_ADDR_W{1'b0}}});
  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;
  assign {w_head_period, w_head_dur} = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_head_ok = !w_empty && (w_head_dur != 16'd0);
  assign w_tick    = (r_presc == c_TICK_LAST);
  assign w_wr_nxt  = r_wr_ptr + {{c_ADDR_W{1'b0}}, w_push};
  assign w_rd_nxt  = r_rd_ptr + {{c_ADDR_W{1'b0}}, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_silence   = 1'b0;
    w_presc_nxt = r_presc;
    w_rem_nxt   = r_rem;
`ifdef TONE_SEQ_GAP_EN
    w_gap_nxt   = r_gap;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_dur == 16'd0) w_done = 1'b1;
          else                     w_load = 1'b1;
        end
      end
      S_PLAY: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          w_rem_nxt = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_done    = 1'b1;
`ifdef TONE_SEQ_GAP_EN
            w_silence   = 1'b1;
            w_state_nxt = S_GAP;
            w_gap_nxt   = c_GAP_W'(GAP_TICKS);
`else
            // A zero-duration head is left for IDLE so its own note_done stays separate.
            if (w_head_ok) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_silence   = 1'b1;
              w_state_nxt = S_IDLE;
            end
`endif
          end
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          w_gap_nxt = r_gap - 1'b1;
          if (r_gap == c_GAP_W'(1)) begin
            if (w_head_ok) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load) begin
      w_state_nxt = S_PLAY;
      w_presc_nxt = '0;
      w_rem_nxt   = w_head_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {cmd_period, cmd_duration};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_rem       <= '0;
      r_count_max <= '0;
      r_osc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_note_done <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
      r_gap       <= '0;
`endif
    end else if (flush) begin
      r_rd_ptr    <= r_wr_ptr;
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_rem       <= '0;
      r_osc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_note_done <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
      r_gap       <= '0;
`endif
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_rem       <= w_rem_nxt;
      r_note_done <= w_done;
      r_busy      <= (w_state_nxt != S_IDLE) || (w_wr_nxt != w_rd_nxt);
`ifdef TONE_SEQ_GAP_EN
      r_gap       <= w_gap_nxt;
`endif
      if (w_load) begin
        r_count_max <= w_head_period;
        r_osc_en    <= (w_head_period != 32'd0);
      end else if (w_silence) begin
        r_osc_en    <= 1'b0;
      end
    end
  end

  assign count_max  = r_count_max;
  assign osc_enable = r_osc_en;
  assign busy       = r_busy;
  assign note_done  = r_note_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// Bench for tone_sequencer: cycle-count queue model checked every cycle, plus directed scenarios.
module tb_tone_sequencer;

  localparam int DEPTH = 4;
  localparam int TD    = 4;
  localparam int GAPT  = 2;
`ifdef TONE_SEQ_GAP_EN
  localparam int REST_EXP  = 12;
  localparam int STALL_EXP = 13;
`else
  localparam int REST_EXP  = 4;
  localparam int STALL_EXP = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] cmd_period = '0;
  logic [15:0] cmd_duration = '0;
  logic        cmd_ready;
  logic [31:0] count_max;
  logic        osc_enable;
  logic        busy;
  logic        note_done;

  tone_sequencer #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TD), .GAP_TICKS(GAPT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_duration(cmd_duration), .flush(flush),
    .count_max(count_max), .osc_enable(osc_enable), .busy(busy), .note_done(note_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: a note lasts duration*TD cycles, a gap GAPT*TD cycles; queue holds pending commands.
  typedef struct packed { logic [31:0] p; logic [15:0] d; } cmd_t;
  cmd_t        mq[$];
  cmd_t        m_h;
  int          m_mode;  // 0 idle, 1 playing, 2 gap
  int          m_left;
  bit          m_acc;
  logic [31:0] e_cm;
  logic        e_en, e_busy, e_done;

  task m_start(input cmd_t h);
    e_cm   = h.p;
    e_en   = (h.p != 0);
    m_left = h.d * TD;
    m_mode = 1;
  endtask

  task m_next_or_idle();
    if (mq.size() > 0 && mq[0].d != 0) m_start(mq.pop_front());
    else begin
      m_mode = 0;
      e_en   = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_mode = 0; m_left = 0;
      e_cm = '0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (flush) begin
        mq.delete();
        m_mode = 0; m_left = 0; e_en = 1'b0;
      end else begin
        m_acc = cmd_valid && (mq.size() < DEPTH);
        case (m_mode)
          0: if (mq.size() > 0) begin
               m_h = mq.pop_front();
               if (m_h.d == 0) e_done = 1'b1;
               else m_start(m_h);
             end
          1: begin
               m_left--;
               if (m_left == 0) begin
                 e_done = 1'b1;
`ifdef TONE_SEQ_GAP_EN
                 m_mode = 2; m_left = GAPT * TD; e_en = 1'b0;
`else
                 m_next_or_idle();
`endif
               end
             end
          default: begin
               m_left--;
               if (m_left == 0) m_next_or_idle();
             end
        endcase
        if (m_acc) mq.push_back({cmd_period, cmd_duration});
      end
      e_busy = (m_mode != 0) || (mq.size() > 0);
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("count_max", count_max, e_cm);
      chk("osc_enable", osc_enable, e_en);
      chk("busy", busy, e_busy);
      chk("note_done", note_done, e_done);
      chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) && !flush);
    end
  end

  // Observation counters used by the literal end-of-scenario checks.
  int          en_cyc, done_cnt, rest_cyc;
  int          en_by_cm [int unsigned];
  logic [31:0] last_cm;
  logic [31:0] order[$];
  bit          en_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (osc_enable) begin
        en_cyc++;
        if (en_by_cm.exists(count_max)) en_by_cm[count_max]++;
        else en_by_cm[count_max] = 1;
      end
      if (note_done) done_cnt++;
      if (busy && !osc_enable && count_max == 0) rest_cyc++;
      if (osc_enable && count_max != last_cm) begin
        order.push_back(count_max);
        last_cm = count_max;
      end
      if (busy) en_log.push_back(osc_enable);
    end
  end

  task clr();
    en_cyc = 0; done_cnt = 0; rest_cyc = 0;
    en_by_cm.delete(); order.delete(); en_log.delete();
    last_cm = '1;
  endtask

  logic [31:0] sp[$];
  logic [15:0] sd[$];

  task automatic push_seq(output int stalls);
    int i = 0;
    int guard = 0;
    stalls = 0;
    while (i < sp.size() && guard < 400) begin
      @(negedge clk); #1;
      cmd_valid = 1'b1; cmd_period = sp[i]; cmd_duration = sd[i];
      if (cmd_ready) i++;
      else stalls++;
      guard++;
    end
    chk("push_seq accepted", i, sp.size());
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || note_done) && n < 500);
    #1;
    chk(name, n < 500, 1);
  endtask

  function automatic logic [31:0] ord(input int i);
    return (i < order.size()) ? order[i] : 32'hDEAD;
  endfunction

  int st;
  bit exp_log[$];

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset count_max", count_max, 0);
    chk("reset osc_enable", osc_enable, 0);
    chk("reset busy", busy, 0);
    chk("reset note_done", note_done, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // single note
    clr(); sp = '{100}; sd = '{3};
    push_seq(st);
    wait_idle("single idle");
    chk("single en cycles", en_cyc, 12);
    chk("single done pulses", done_cnt, 1);
    chk("single count_max held", count_max, 100);

    // back-to-back tone, tone, rest
    clr(); sp = '{10, 20, 0}; sd = '{1, 2, 1};
    push_seq(st);
    wait_idle("b2b idle");
    chk("b2b cm10 cycles", en_by_cm.exists(10) ? en_by_cm[10] : 0, 4);
    chk("b2b cm20 cycles", en_by_cm.exists(20) ? en_by_cm[20] : 0, 8);
    chk("b2b rest cycles", rest_cyc, REST_EXP);
    chk("b2b done pulses", done_cnt, 3);
    chk("b2b order0", ord(0), 10);
    chk("b2b order1", ord(1), 20);

    // skipped note
    clr(); sp = '{30}; sd = '{0};
    push_seq(st);
    wait_idle("skip idle");
    chk("skip done pulses", done_cnt, 1);
    chk("skip en cycles", en_cyc, 0);
    chk("skip count_max unchanged", count_max, 0);

    // full queue with continuous valid
    clr(); sp = '{11, 12, 13, 14, 15, 16}; sd = '{2, 1, 1, 1, 1, 1};
    push_seq(st);
    chk("full stall cycles", st, STALL_EXP);
    wait_idle("full idle");
    chk("full order count", order.size(), 6);
    for (int i = 0; i < 6; i++) chk("full order", ord(i), 11 + i);
    chk("full done pulses", done_cnt, 6);

    // flush mid-note with queued commands and a same-cycle push
    clr(); sp = '{21, 22, 23, 24}; sd = '{4, 1, 1, 1};
    push_seq(st);
    repeat (2) @(negedge clk);
    #1;
    flush = 1'b1; cmd_valid = 1'b1; cmd_period = 99; cmd_duration = 1;
    #1 chk("flush cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    clr();
    @(negedge clk);
    chk("flush osc_enable", osc_enable, 0);
    chk("flush busy", busy, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("flush no done", done_cnt, 0);
    chk("flush no tone", en_cyc, 0);
    sp = '{25}; sd = '{1};
    push_seq(st);
    wait_idle("after flush idle");
    chk("after flush order", ord(0), 25);
    chk("after flush order count", order.size(), 1);
    chk("after flush en cycles", en_cyc, 4);

`ifdef TONE_SEQ_GAP_EN
    // gap between notes keeps busy high
    clr(); sp = '{10, 20}; sd = '{1, 1};
    push_seq(st);
    wait_idle("gap idle");
    exp_log.delete();
    exp_log.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_log.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_log.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_log.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_log.push_back(1'b0);
    chk("gap busy cycles", en_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      chk("gap en pattern", (i < en_log.size()) ? en_log[i] : 1'bx, exp_log[i]);
`endif

    // asynchronous reset mid-note
    clr(); sp = '{40}; sd = '{5};
    push_seq(st);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count_max", count_max, 0);
    chk("async rst osc_enable", osc_enable, 0);
    chk("async rst busy", busy, 0);
    chk("async rst cmd_ready", cmd_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clr(); sp = '{50}; sd = '{1};
    push_seq(st);
    wait_idle("post reset idle");
    chk("post reset order", ord(0), 50);
    chk("post reset en cycles", en_cyc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Queues note commands (oscillator period plus duration) and plays them in order by driving the pulse oscillator's count_max and a gate enable.
- Sits between the control/register side and the square-wave oscillator, so that melodies are played without any cycle-accurate software timing.
- Durations are counted in prescaled ticks derived from clk.

Parameters:
FIFO_DEPTH, 4, command queue depth in entries; power of 2, minimum 2.
TICK_DIV, 48000, clk cycles per duration tick; minimum 1.
GAP_TICKS, 1, length of the silent gap between notes in ticks; used only when TONE_SEQ_GAP_EN is defined; minimum 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  note command present.
cmd_ready  output  1  queue can accept; combinational !full && !flush.
cmd_period  input  32  oscillator count_max for the note; 0 means rest (silence).
cmd_duration  input  16  note length in ticks; 0 means skip the note.
flush  input  1  synchronous abort: empty the queue and stop the current note.
count_max  output  32  registered; connects to oscillator count_max.
osc_enable  output  1  registered gate; downstream ANDs it with the oscillator data.
busy  output  1  registered; 1 while a note or gap is active or the queue is non-empty.
note_done  output  1  registered single-cycle pulse when a note finishes or is skipped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - queue emptied; FSM goes to IDLE; prescaler and remaining-tick counter cleared.
  - count_max=0, osc_enable=0, busy=0, note_done=0.
  - cmd_ready=1, because the queue is not full.
- Handshake:
  - A push occurs on an edge where cmd_valid && cmd_ready; {period, duration} is written to the queue.
  - cmd_valid may drop without a transfer. The producer must hold its data only while waiting for ready.
  - When the queue is full, cmd_ready=0 even if a pop occurs in the same cycle; there is no full-bypass.
  - Push and pop in the same cycle are allowed when the queue is not full; occupancy is then unchanged.
- FSM states: IDLE, PLAY, plus GAP under the optional feature.
- IDLE:
  - If the queue is non-empty, pop the head.
  - If the popped duration is 0: pulse note_done the next cycle and stay in IDLE. count_max and osc_enable are unchanged (osc_enable stays 0).
  - Otherwise: count_max<=period, osc_enable<=(period!=0), remaining<=duration, prescaler<=0, go to PLAY.
  - Latency: a command pushed into an empty queue at edge N is popped at edge N+1. count_max and osc_enable are valid after edge N+1.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1 and wraps. Each wrap is one tick, and remaining decrements on it.
  - On the wrap where remaining==1, pulse note_done for one cycle. The note therefore lasts exactly duration*TICK_DIV cycles of osc_enable.
  - If the queue is non-empty on that edge, pop and load the next note on the same edge, so notes play back-to-back with no dead cycle. note_done and the new count_max appear together.
  - If the queue is empty: osc_enable<=0, count_max holds its last value, go to IDLE.
- busy: registered from (state!=IDLE || queue non-empty) as computed for the next state.
- flush (priority over everything except reset):
  - on the edge where flush=1: queue emptied, state<=IDLE, osc_enable<=0, count_max held, prescaler and remaining cleared.
  - no note_done pulse; a push presented in the same cycle is dropped (cmd_ready=0).
- Arithmetic:
  - The prescaler is clog2(TICK_DIV) bits wide (at least 1 bit); remaining is 16 bits; queue pointers carry one extra wrap bit.
  - All counters wrap only as specified; no counter overflows, by construction.
- Rest note (period 0, duration>0): timed exactly like a tone with osc_enable=0. count_max is still loaded with 0.

Optional Feature:
- TONE_SEQ_GAP_EN defined:
  - After the final tick of every note (including rest notes; not skipped notes), enter GAP for GAP_TICKS ticks: osc_enable=0, count_max held.
  - Then go to IDLE, or pop the next note directly at the end of the gap if the queue is non-empty.
  - note_done pulses at note end, not at gap end. busy=1 during GAP. flush aborts GAP.
- Not defined: GAP state and its counter are absent; notes play back-to-back as described above.

Test Plan:
- Reset/idle, TICK_DIV=4: rst_n low mid-note → count_max=0, osc_enable=0, busy=0 immediately (asynchronous). After release, cmd_ready=1.
- Single note {period=100, duration=3} pushed at edge N → count_max=100 and osc_enable=1 from N+1 for exactly 12 cycles. note_done pulses once; then osc_enable=0, busy=0, count_max stays 100.
- Back-to-back, macro off: push {10,1},{20,2},{0,1} → osc_enable high 4 cycles at count_max 10, then 8 cycles at count_max 20, then low 4 cycles (rest). Three note_done pulses with no dead cycle between notes; a skipped {30,0} gives a note_done pulse with no output change.
- Full queue, FIFO_DEPTH=4: hold cmd_valid high with distinct periods while the first note plays → 1 note popped plus 4 queued, cmd_ready=0 until the next pop. No command is lost or duplicated; play order is preserved.
- Flush mid-note with 3 queued and cmd_valid=1 → osc_enable=0 on the next edge, busy=0, no note_done pulse, the same-cycle push is dropped. A new note pushed afterwards plays normally.
- TONE_SEQ_GAP_EN, GAP_TICKS=2, TICK_DIV=4: push {10,1},{20,1} → 4 cycles on, 8 cycles off, then 4 cycles on. busy stays 1 throughout.
